tilemap_scroller: RTL and testbench
===================================

TILEMAP_SCROLLER -- requirements
Module: tilemap_scroller

Interface
REQ-001 Parameter TILE_COLS, default 40, tiles per map row; RAM address = col + row*TILE_COLS.
REQ-002 Parameter SCROLL_ROW_FIRST, default 7, first scrolled map row; rows below it (HUD) are never written.
REQ-003 Parameter SCROLL_ROW_LAST, default 29, last scrolled map row.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-007 scroll_en  in  1  high = advance scroll on each frame_tick.
REQ-008 speed  in  3  pixels scrolled per frame, 0..7.
REQ-009 ram_addr  out  16  tile-map RAM port B address.
REQ-010 ram_rdata  in  16  port B read data, valid one cycle after ram_addr.
REQ-011 ram_we  out  1  port B write enable.
REQ-012 ram_wdata  out  16  port B write data.
REQ-013 gen_req  out  1  request new tile for column TILE_COLS-1.
REQ-014 gen_row  out  5  map row of the request, stable while gen_req high.
REQ-015 gen_ack  in  1  new tile valid on gen_tile this cycle.
REQ-016 gen_tile  in  16  new tile entry (background tile format).
REQ-017 x_offset  out  4  fine scroll offset to background engine.
REQ-018 busy  out  1  high while a column shift is in progress.
REQ-019 tiles_scrolled  out  16  count of completed column shifts, wraps 0xFFFF->0.
REQ-020 overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Function
REQ-021 On frame_tick with scroll_en=1 and busy=0: acc = x_offset + speed (5-bit); if acc<16, x_offset <= acc next cycle, no shift.
REQ-022 If acc>=16: x_offset unchanged, busy rises next cycle, shift begins; x_offset <= acc-16 only in the DONE cycle.
REQ-023 FSM states: IDLE, READ, WRITE, GEN_REQ, DONE.
REQ-024 READ: ram_addr = row*TILE_COLS + col + 1, ram_we=0; always -> WRITE.
REQ-025 WRITE: ram_addr = row*TILE_COLS + col, ram_wdata = ram_rdata, ram_we=1; col++; at col = TILE_COLS-2 after write -> GEN_REQ.
REQ-026 GEN_REQ: gen_req=1, gen_row=row held until gen_ack; on gen_ack write gen_tile to col TILE_COLS-1 same cycle, gen_req drops next cycle.
REQ-027 After column TILE_COLS-1 write: if row<SCROLL_ROW_LAST, row++, col=0 -> READ; else -> DONE.
REQ-028 DONE (one cycle): update x_offset, tiles_scrolled++, busy<=0 next cycle, -> IDLE.
REQ-029 Shift of default map takes 23 rows * (78 + 1 + gen latency) cycles; must fit vblank.
REQ-030 frame_tick while busy: ignored for scrolling, overrun pulses next cycle.
REQ-031 scroll_en or speed change while busy: no effect on current shift; acc latched at start.
REQ-032 frame_tick with scroll_en=0 or speed=0: no state change.
REQ-033 ram_we=0 in IDLE, READ, DONE and GEN_REQ before gen_ack.

Reset
REQ-034 rst_n low: FSM IDLE, x_offset=0, tiles_scrolled=0, busy=0, overrun=0, ram_we=0, gen_req=0, ram_addr=0, ram_wdata=0, immediately (asynchronous).
REQ-035 Reset mid-shift aborts shift without further RAM writes; partially shifted map left as is.

Structure
REQ-036 Shared package holds TILE_WIDTH=16, TILE_COLS, TILE_ROWS, the FSM state encoding and the tile entry field positions (col, row, x-flip, y-flip, enable).
REQ-037 Single module, no sub-modules; address computed with one multiply-free row-base register incremented by TILE_COLS per row.

Verification
REQ-038 x_offset=0, speed=5, three ticks -> x_offset 5, 10, 15; busy never high; no RAM writes.
REQ-039 x_offset=14, speed=3, tick -> busy high, 23*40 writes, entry (7,0) takes old (7,1), (29,39) takes gen_tile; then x_offset=1, tiles_scrolled=1.
REQ-040 gen_ack delayed 5 cycles on row 12 -> gen_req held with gen_row=12, no write until ack, write value = gen_tile at ack.
REQ-041 frame_tick mid-shift -> overrun one-cycle pulse, x_offset and shift unaffected.
REQ-042 rst_n low at row 15 of shift -> all outputs reset same cycle, rows 0..6 untouched, ram_we stays 0 after release until next shift.
REQ-043 tiles_scrolled preset to 0xFFFF by forcing 65535 shifts (or backdoor) -> next shift yields 0.

Source files
------------

// File: rtl/tilemap_scroller_pkg.sv
// rtl/tilemap_scroller_pkg.sv - shared constants, FSM encoding and tile entry layout
package tilemap_scroller_pkg;

    localparam int TILE_WIDTH = 16;
    localparam int TILE_COLS  = 40;
    localparam int TILE_ROWS  = 30;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_GEN_REQ = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Background tile entry layout: tileset column/row, flips, enable.
    localparam int TILE_FIELD_W   = 5;
    localparam int TILE_COL_LSB   = 0;
    localparam int TILE_ROW_LSB   = 5;
    localparam int TILE_XFLIP_BIT = 10;
    localparam int TILE_YFLIP_BIT = 11;
    localparam int TILE_EN_BIT    = 15;

    function automatic logic [TILE_WIDTH-1:0] make_tile(
        input logic [TILE_FIELD_W-1:0] tcol,
        input logic [TILE_FIELD_W-1:0] trow,
        input logic                    xflip,
        input logic                    yflip,
        input logic                    en
    );
        logic [TILE_WIDTH-1:0] t;
        t = '0;
        t[TILE_COL_LSB +: TILE_FIELD_W] = tcol;
        t[TILE_ROW_LSB +: TILE_FIELD_W] = trow;
        t[TILE_XFLIP_BIT]               = xflip;
        t[TILE_YFLIP_BIT]               = yflip;
        t[TILE_EN_BIT]                  = en;
        return t;
    endfunction

endpackage

// File: rtl/tilemap_scroller_if.sv
// rtl/tilemap_scroller_if.sv - tile-map RAM port B and new-tile generator handshake
interface tilemap_scroller_if;
    import tilemap_scroller_pkg::*;

    logic [15:0]           ram_addr;
    logic [TILE_WIDTH-1:0] ram_rdata;
    logic                  ram_we;
    logic [TILE_WIDTH-1:0] ram_wdata;
    logic                  gen_req;
    logic [4:0]            gen_row;
    logic                  gen_ack;
    logic [TILE_WIDTH-1:0] gen_tile;

    modport master (
        output ram_addr, ram_we, ram_wdata, gen_req, gen_row,
        input  ram_rdata, gen_ack, gen_tile
    );

    modport slave (
        input  ram_addr, ram_we, ram_wdata, gen_req, gen_row,
        output ram_rdata, gen_ack, gen_tile
    );

endinterface

// File: rtl/tilemap_scroller.sv
// rtl/tilemap_scroller.sv - fine/coarse horizontal scroller shifting tile-map columns left
module tilemap_scroller #(
    parameter int TILE_COLS        = tilemap_scroller_pkg::TILE_COLS,
    parameter int SCROLL_ROW_FIRST = 7,
    parameter int SCROLL_ROW_LAST  = 29
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                scroll_en,
    input  logic [2:0]          speed,
    tilemap_scroller_if.master  bus,
    output logic [3:0]          x_offset,
    output logic                busy,
    output logic [15:0]         tiles_scrolled,
    output logic                overrun
);
    import tilemap_scroller_pkg::*;

    localparam int               COL_W          = 8;
    localparam logic [15:0]      COLS16         = 16'(TILE_COLS);
    localparam logic [15:0]      FIRST_BASE     = 16'(SCROLL_ROW_FIRST * TILE_COLS);
    localparam logic [COL_W-1:0] COL_LAST_SHIFT = COL_W'(TILE_COLS - 2);
    localparam logic [4:0]       ROW_FIRST      = 5'(SCROLL_ROW_FIRST);
    localparam logic [4:0]       ROW_LAST       = 5'(SCROLL_ROW_LAST);

    state_t           state;
    logic [4:0]       row;
    logic [COL_W-1:0] col;
    logic [15:0]      row_base;   // row*TILE_COLS kept incrementally, no multiplier
    logic [3:0]       acc_rem;    // fine offset left over once the shift completes
    logic [4:0]       acc;

    assign acc = {1'b0, x_offset} + {2'b00, speed};

    // Scroll control FSM: fine offset update, column shift sequencing, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            row            <= '0;
            col            <= '0;
            row_base       <= '0;
            acc_rem        <= '0;
            x_offset       <= '0;
            busy           <= 1'b0;
            tiles_scrolled <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= frame_tick && busy;
            case (state)
                ST_IDLE: begin
                    if (frame_tick && scroll_en && speed != 3'd0) begin
                        if (acc[4]) begin
                            // Offset stays put until the map has actually moved one tile.
                            busy     <= 1'b1;
                            acc_rem  <= acc[3:0];
                            row      <= ROW_FIRST;
                            row_base <= FIRST_BASE;
                            col      <= '0;
                            state    <= ST_READ;
                        end else begin
                            x_offset <= acc[3:0];
                        end
                    end
                end
                ST_READ: state <= ST_WRITE;
                ST_WRITE: begin
                    col   <= col + COL_W'(1);
                    state <= (col == COL_LAST_SHIFT) ? ST_GEN_REQ : ST_READ;
                end
                ST_GEN_REQ: begin
                    if (bus.gen_ack) begin
                        if (row < ROW_LAST) begin
                            row      <= row + 5'd1;
                            row_base <= row_base + COLS16;
                            col      <= '0;
                            state    <= ST_READ;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    x_offset       <= acc_rem;
                    tiles_scrolled <= tiles_scrolled + 16'd1;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM port decode from the current state; generator tile is written in its ack cycle
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        case (state)
            ST_READ: bus.ram_addr = row_base + {8'd0, col} + 16'd1;
            ST_WRITE: begin
                bus.ram_addr  = row_base + {8'd0, col};
                bus.ram_we    = 1'b1;
                bus.ram_wdata = bus.ram_rdata;
            end
            ST_GEN_REQ: begin
                bus.ram_addr = row_base + COLS16 - 16'd1;
                if (bus.gen_ack) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = bus.gen_tile;
                end
            end
            default: ;
        endcase
    end

    assign bus.gen_req = (state == ST_GEN_REQ);
    assign bus.gen_row = row;

endmodule

// File: tb/tb_tilemap_scroller.sv
// tb/tb_tilemap_scroller.sv - randomized bench with behavioural map-shift model
module tb_tilemap_scroller;
    import tilemap_scroller_pkg::*;

    localparam int FIRST = 7;
    localparam int LAST  = 29;
    localparam int NCOLS = TILE_COLS;
    localparam int MSIZE = TILE_ROWS * NCOLS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       scroll_en = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [3:0] x_offset;
    logic       busy;
    logic [15:0] tiles_scrolled;
    logic       overrun;

    tilemap_scroller_if bus();

    tilemap_scroller #(.TILE_COLS(NCOLS), .SCROLL_ROW_FIRST(FIRST), .SCROLL_ROW_LAST(LAST)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .speed(speed), .bus(bus), .x_offset(x_offset), .busy(busy),
        .tiles_scrolled(tiles_scrolled), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem  [0:MSIZE-1];
    logic [15:0] snap [0:MSIZE-1];
    logic [15:0] tile_log [0:31];
    int write_count = 0;
    int hud_writes  = 0;
    int gen_delay   = 0;
    int delay_row   = -1;
    int delay_long  = 0;
    int wait_cnt    = 0;
    int model_xoff  = 0;
    int model_count = 0;
    int pend_xoff   = 0;

    // Synchronous-read tile-map RAM
    always @(posedge clk) begin
        bus.ram_rdata <= (int'(bus.ram_addr) < MSIZE) ? mem[int'(bus.ram_addr)] : 16'h0;
        if (bus.ram_we) begin
            if (int'(bus.ram_addr) < MSIZE) mem[int'(bus.ram_addr)] = bus.ram_wdata;
            write_count = write_count + 1;
            if (int'(bus.ram_addr) < FIRST * NCOLS) hud_writes = hud_writes + 1;
        end
    end

    // New-tile generator answering after a programmable number of cycles
    always begin
        int d;
        logic [15:0] t;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            bus.gen_ack = 1'b0;
            wait_cnt = 0;
        end else if (bus.gen_ack) begin
            bus.gen_ack = 1'b0;
        end else if (bus.gen_req) begin
            d = (int'(bus.gen_row) == delay_row) ? delay_long : gen_delay;
            if (wait_cnt >= d) begin
                t = make_tile(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'b1);
                bus.gen_tile = t;
                tile_log[bus.gen_row] = t;
                bus.gen_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < MSIZE; i++) mem[i] = 16'($urandom);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        scroll_en = 1'b0;
        speed = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_xoff = 0;
        model_count = 0;
    endtask

    // One frame tick; the model predicts fine step or a pending shift
    task automatic tick(input logic [2:0] spd, input logic en, output bit shifted);
        int acc;
        speed = spd;
        scroll_en = en;
        for (int i = 0; i < MSIZE; i++) snap[i] = mem[i];
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        shifted = 1'b0;
        if (en && spd != 3'd0) begin
            acc = model_xoff + int'(spd);
            if (acc < 16) model_xoff = acc;
            else begin
                shifted = 1'b1;
                pend_xoff = acc - 16;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        model_xoff = pend_xoff;
        model_count = (model_count + 1) & 16'hFFFF;
    endtask

    // Every scrolled row moves left by one entry and takes the generator tile at its end
    task automatic check_map(input string name);
        int bad;
        int first_bad;
        logic [15:0] exp_v;
        bad = 0;
        first_bad = -1;
        for (int r = 0; r < TILE_ROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (r < FIRST || r > LAST) exp_v = snap[r * NCOLS + c];
                else if (c < NCOLS - 1) exp_v = snap[r * NCOLS + c + 1];
                else exp_v = tile_log[r];
                if (mem[r * NCOLS + c] !== exp_v) begin
                    bad++;
                    if (first_bad < 0) first_bad = r * NCOLS + c;
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s map: %0d wrong entries (first at index %0d), required 0", name, bad, first_bad);
        end
    endtask

    task automatic check_state(input string name);
        checks++;
        if (x_offset !== 4'(model_xoff)) begin
            errors++;
            $display("FAIL %s x_offset: got %0d, required %0d", name, x_offset, model_xoff);
        end
        checks++;
        if (tiles_scrolled !== 16'(model_count)) begin
            errors++;
            $display("FAIL %s tiles_scrolled: got %0d, required %0d", name, tiles_scrolled, model_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (x_offset !== 4'd0) begin errors++; $display("FAIL reset x_offset: got %0d, required 0", x_offset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
        checks++; if (tiles_scrolled !== 16'd0) begin errors++; $display("FAIL reset tiles_scrolled: got %0d, required 0", tiles_scrolled); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b, required 0", overrun); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset ram_we: got %b, required 0", bus.ram_we); end
        checks++; if (bus.gen_req !== 1'b0) begin errors++; $display("FAIL reset gen_req: got %b, required 0", bus.gen_req); end
        checks++; if (bus.ram_addr !== 16'd0) begin errors++; $display("FAIL reset ram_addr: got %0d, required 0", bus.ram_addr); end
        checks++; if (bus.ram_wdata !== 16'd0) begin errors++; $display("FAIL reset ram_wdata: got %h, required 0", bus.ram_wdata); end
        reset_dut();
    endtask

    task automatic test_fine_scroll();
        bit s;
        int w0;
        reset_dut();
        w0 = write_count;
        for (int i = 0; i < 3; i++) begin
            tick(3'd5, 1'b1, s);
            check_state("fine");
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL fine busy: got %b, required 0", busy); end
        end
        tick(3'd3, 1'b0, s);
        check_state("fine_disabled");
        tick(3'd0, 1'b1, s);
        check_state("fine_speed0");
        checks++;
        if (write_count - w0 !== 0) begin
            errors++;
            $display("FAIL fine writes: got %0d, required 0", write_count - w0);
        end
    endtask

    task automatic test_shift();
        bit s;
        int w0;
        reset_dut();
        fill_mem();
        gen_delay = 0;
        tick(3'd7, 1'b1, s);
        tick(3'd7, 1'b1, s);
        check_state("shift_pre");
        w0 = write_count;
        tick(3'd3, 1'b1, s);
        checks++;
        if (busy !== s) begin errors++; $display("FAIL shift busy_rise: got %b, required %b", busy, s); end
        checks++;
        if (x_offset !== 4'd14) begin errors++; $display("FAIL shift x_hold: got %0d, required 14", x_offset); end
        repeat (50) @(negedge clk);
        speed = 3'($urandom);
        scroll_en = 1'b0;
        wait_idle("shift");
        checks++;
        if (write_count - w0 !== (LAST - FIRST + 1) * NCOLS) begin
            errors++;
            $display("FAIL shift writes: got %0d, required %0d", write_count - w0, (LAST - FIRST + 1) * NCOLS);
        end
        checks++;
        if (mem[FIRST * NCOLS] !== snap[FIRST * NCOLS + 1]) begin
            errors++;
            $display("FAIL shift entry_7_0: got %h, required %h", mem[FIRST * NCOLS], snap[FIRST * NCOLS + 1]);
        end
        checks++;
        if (mem[LAST * NCOLS + NCOLS - 1] !== tile_log[LAST]) begin
            errors++;
            $display("FAIL shift entry_29_39: got %h, required %h", mem[LAST * NCOLS + NCOLS - 1], tile_log[LAST]);
        end
        checks++;
        if (hud_writes !== 0) begin errors++; $display("FAIL shift hud_writes: got %0d, required 0", hud_writes); end
        check_map("shift");
        check_state("shift_post");
    endtask

    task automatic test_gen_delay();
        bit s;
        int n;
        reset_dut();
        fill_mem();
        gen_delay = 1;
        delay_row = 12;
        delay_long = 5;
        tick(3'd7, 1'b1, s);
        tick(3'd7, 1'b1, s);
        tick(3'd6, 1'b1, s);
        n = 0;
        while (!(busy && bus.gen_req && int'(bus.gen_row) == 12) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.gen_req !== 1'b1 || int'(bus.gen_row) != 12) begin
                errors++;
                $display("FAIL gen_delay hold[%0d]: gen_req=%b gen_row=%0d, required 1/12", i, bus.gen_req, bus.gen_row);
            end
            checks++;
            if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL gen_delay early_write[%0d]: ram_we=%b, required 0", i, bus.ram_we); end
        end
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_wdata !== tile_log[12] || int'(bus.ram_addr) != 12 * NCOLS + NCOLS - 1) begin
            errors++;
            $display("FAIL gen_delay ack_write: we=%b data=%h addr=%0d, required 1/%h/%0d",
                     bus.ram_we, bus.ram_wdata, bus.ram_addr, tile_log[12], 12 * NCOLS + NCOLS - 1);
        end
        wait_idle("gen_delay");
        delay_row = -1;
        check_map("gen_delay");
        check_state("gen_delay");
    endtask

    task automatic test_overrun();
        bit s;
        reset_dut();
        fill_mem();
        gen_delay = 2;
        tick(3'd7, 1'b1, s);
        tick(3'd7, 1'b1, s);
        tick(3'd4, 1'b1, s);
        repeat (100) @(negedge clk);
        speed = 3'd7;
        scroll_en = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun pulse: got %b, required 1", overrun); end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun width: got %b, required 0", overrun); end
        wait_idle("overrun");
        check_map("overrun");
        check_state("overrun");
    endtask

    task automatic test_reset_mid_shift();
        bit s;
        int n;
        int w0;
        int bad;
        reset_dut();
        fill_mem();
        gen_delay = 0;
        tick(3'd7, 1'b1, s);
        tick(3'd7, 1'b1, s);
        tick(3'd2, 1'b1, s);
        n = 0;
        while (!(busy && int'(bus.gen_row) == 15) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat ($urandom_range(0, 60)) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.ram_we !== 1'b0 || bus.gen_req !== 1'b0 || x_offset !== 4'd0 ||
            tiles_scrolled !== 16'd0 || bus.ram_addr !== 16'd0 || bus.ram_wdata !== 16'd0) begin
            errors++;
            $display("FAIL abort outputs: busy=%b we=%b req=%b x=%0d cnt=%0d addr=%0d wdata=%h, required all 0",
                     busy, bus.ram_we, bus.gen_req, x_offset, tiles_scrolled, bus.ram_addr, bus.ram_wdata);
        end
        w0 = write_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_xoff = 0;
        model_count = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (write_count - w0 !== 0) begin errors++; $display("FAIL abort writes: got %0d, required 0", write_count - w0); end
        bad = 0;
        for (int i = 0; i < FIRST * NCOLS; i++) if (mem[i] !== snap[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort hud: %0d entries changed, required 0", bad); end
        check_state("abort");
    endtask

    task automatic test_random();
        bit s;
        reset_dut();
        fill_mem();
        for (int it = 0; it < 14; it++) begin
            gen_delay = $urandom_range(0, 3);
            tick(3'($urandom), ($urandom_range(0, 4) != 0), s);
            if (s) begin
                wait_idle("random");
                check_map("random");
            end
            check_state("random");
        end
    endtask

    task automatic test_wrap();
        bit s;
        reset_dut();
        fill_mem();
        gen_delay = 0;
        force dut.tiles_scrolled = 16'hFFFF;
        @(negedge clk);
        release dut.tiles_scrolled;
        @(negedge clk);
        model_count = 16'hFFFF;
        tick(3'd7, 1'b1, s);
        tick(3'd7, 1'b1, s);
        tick(3'd3, 1'b1, s);
        wait_idle("wrap");
        checks++;
        if (tiles_scrolled !== 16'd0) begin errors++; $display("FAIL wrap count: got %0d, required 0", tiles_scrolled); end
        check_state("wrap");
    endtask

    initial begin
        bus.gen_ack = 1'b0;
        bus.gen_tile = 16'h0;
        fill_mem();
        test_reset();
        test_fine_scroll();
        test_shift();
        test_gen_delay();
        test_overrun();
        test_reset_mid_shift();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
